// File: rtl/irqc_pkg.sv
// Shared definitions for the interrupt controller: peripheral bus payloads,
// register offsets, default sizing and fixed source ID assignments.
package irqc_pkg;

    localparam int unsigned DBUS_ADDR_W = 32;
    localparam int unsigned DBUS_DATA_W = 32;

    typedef struct packed {
        logic [DBUS_ADDR_W-1:0] addr;
        logic [DBUS_DATA_W-1:0] w_data;
        logic                   w_en;
        logic                   req;
    } type_dbus2peri_s;

    typedef struct packed {
        logic [DBUS_DATA_W-1:0] r_data;
        logic                   ack;
    } type_peri2dbus_s;

    localparam int unsigned IRQC_NUM_SRC = 8;
    localparam int unsigned IRQC_PRIO_W  = 3;
    localparam int unsigned IRQC_MAX_SRC = 31;

    localparam logic [7:0] REG_PENDING   = 8'h00;
    localparam logic [7:0] REG_ENABLE    = 8'h04;
    localparam logic [7:0] REG_TRIGGER   = 8'h08;
    localparam logic [7:0] REG_THRESHOLD = 8'h0C;
    localparam logic [7:0] REG_CLAIM     = 8'h10;
    localparam logic [7:0] REG_PRIO_BASE = 8'h20;

    localparam logic [4:0] IRQ_ID_NONE  = 5'd0;
    localparam logic [4:0] IRQ_ID_GPIO  = 5'd1;
    localparam logic [4:0] IRQ_ID_UART  = 5'd2;
    localparam logic [4:0] IRQ_ID_TIMER = 5'd3;

    // Byte offset of the priority register for source index idx
    function automatic logic [7:0] prio_offset(input int idx);
        return REG_PRIO_BASE + 8'(4 * idx);
    endfunction

endpackage

// File: rtl/irqc_gateway.sv
// Per-source interrupt gateway: level/edge detection plus pending and
// in-service tracking driven by claim/complete strobes.
module irqc_gateway (
    input  logic clk,
    input  logic rst,
    input  logic src,
    input  logic mode,
    input  logic claim,
    input  logic complete,
    output logic pending,
    output logic in_service
);

    logic src_prev;
    logic set_c;

    // mode=1 catches rising edges, mode=0 follows the level; nothing while in service
    always_comb begin
        set_c = 1'b0;
        if (!in_service) begin
            set_c = mode ? (src & ~src_prev) : (src & ~pending);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_prev   <= 1'b0;
            pending    <= 1'b0;
            in_service <= 1'b0;
        end else begin
            src_prev <= src;
            if (claim) begin
                pending    <= 1'b0;
                in_service <= 1'b1;
            end else begin
                if (set_c) begin
                    pending <= 1'b1;
                end
                if (complete) begin
                    in_service <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Platform interrupt controller: per-source gateways, priority arbiter,
// register file and claim/complete over the peripheral data bus.
module irq_ctrl
    import irqc_pkg::*;
#(
    parameter int unsigned NUM_SRC = IRQC_NUM_SRC,
    parameter int unsigned PRIO_W  = IRQC_PRIO_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                irqc_sel_i,
    input  type_dbus2peri_s     dbus2irqc_i,
    output type_peri2dbus_s     irqc2dbus_o,
    input  logic [NUM_SRC-1:0]  irq_src_i,
    output logic                ext_irq_o
);

    localparam int unsigned ID_W = $clog2(NUM_SRC + 1);

    logic [NUM_SRC-1:0] enable_q;
    logic [NUM_SRC-1:0] trigger_q;
    logic [PRIO_W-1:0]  threshold_q;
    logic [PRIO_W-1:0]  prio_q [NUM_SRC];
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] in_service;
    logic               ack_q;
    logic [DBUS_DATA_W-1:0] r_data_q;

    logic               txn_c;
    logic               wr_c;
    logic               rd_c;
    logic [7:0]         addr_c;
    logic               claim_c;
    logic               complete_c;
    logic [NUM_SRC-1:0] claim_vec_c;
    logic [NUM_SRC-1:0] complete_vec_c;
    logic [PRIO_W-1:0]  best_prio_c;
    logic [ID_W-1:0]    best_id_c;
    logic [DBUS_DATA_W-1:0] rd_data_c;
    logic               unused_addr;

    assign addr_c      = dbus2irqc_i.addr[7:0];
    assign unused_addr = ^dbus2irqc_i.addr[DBUS_ADDR_W-1:8];
    assign txn_c       = dbus2irqc_i.req & irqc_sel_i;
    assign wr_c        = txn_c & dbus2irqc_i.w_en;
    assign rd_c        = txn_c & ~dbus2irqc_i.w_en;
    assign claim_c     = rd_c & (addr_c == REG_CLAIM) & (best_id_c != '0);
    assign complete_c  = wr_c & (addr_c == REG_CLAIM);

    // Claim targets the current winner; complete only touches an in-service source
    always_comb begin
        claim_vec_c    = '0;
        complete_vec_c = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            claim_vec_c[i]    = claim_c & (best_id_c == ID_W'(i + 1));
            complete_vec_c[i] = complete_c & in_service[i]
                              & (dbus2irqc_i.w_data == DBUS_DATA_W'(i + 1));
        end
    end

    // Bit 0 carries the GPIO interrupt line
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_gw
        irqc_gateway u_gw (
            .clk        (clk),
            .rst        (rst),
            .src        (irq_src_i[g]),
            .mode       (trigger_q[g]),
            .claim      (claim_vec_c[g]),
            .complete   (complete_vec_c[g]),
            .pending    (pending[g]),
            .in_service (in_service[g])
        );
    end

    // Highest priority wins; strict compare keeps the lowest index on a tie
    always_comb begin
        best_prio_c = '0;
        best_id_c   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pending[i] && enable_q[i] && (prio_q[i] > threshold_q)
                && (prio_q[i] > best_prio_c)) begin
                best_prio_c = prio_q[i];
                best_id_c   = ID_W'(i + 1);
            end
        end
    end

    always_comb begin
        rd_data_c = '0;
        case (addr_c)
            REG_PENDING:   rd_data_c = DBUS_DATA_W'(pending);
            REG_ENABLE:    rd_data_c = DBUS_DATA_W'(enable_q);
            REG_TRIGGER:   rd_data_c = DBUS_DATA_W'(trigger_q);
            REG_THRESHOLD: rd_data_c = DBUS_DATA_W'(threshold_q);
            REG_CLAIM:     rd_data_c = DBUS_DATA_W'(best_id_c);
            default:       rd_data_c = '0;
        endcase
        for (int i = 0; i < NUM_SRC; i++) begin
            if (addr_c == prio_offset(i)) begin
                rd_data_c = DBUS_DATA_W'(prio_q[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enable_q    <= '0;
            trigger_q   <= '0;
            threshold_q <= '0;
            ack_q       <= 1'b0;
            r_data_q    <= '0;
            ext_irq_o   <= 1'b0;
            for (int i = 0; i < NUM_SRC; i++) begin
                prio_q[i] <= '0;
            end
        end else begin
            ack_q     <= txn_c;
            r_data_q  <= rd_c ? rd_data_c : '0;
            ext_irq_o <= (best_id_c != '0);
            if (wr_c) begin
                case (addr_c)
                    REG_ENABLE:    enable_q    <= dbus2irqc_i.w_data[NUM_SRC-1:0];
                    REG_TRIGGER:   trigger_q   <= dbus2irqc_i.w_data[NUM_SRC-1:0];
                    REG_THRESHOLD: threshold_q <= dbus2irqc_i.w_data[PRIO_W-1:0];
                    default:       ;
                endcase
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (addr_c == prio_offset(i)) begin
                        prio_q[i] <= dbus2irqc_i.w_data[PRIO_W-1:0];
                    end
                end
            end
        end
    end

    assign irqc2dbus_o = '{r_data: r_data_q, ack: ack_q};

endmodule
